inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_pkg.sv | 17 +
 rtl/inst_mem.sv | 31 +++
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, word type, NOP/HALT encodings and fetch states.
package cpu_pkg;

    localparam int unsigned INST_W = 32;

    typedef logic [INST_W-1:0] word_t;

    // inst[2:0] = 7 tells the downstream core not to write back
    localparam word_t NOP  = 32'h0000_0007;
    localparam word_t HALT = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_mem.sv
// Instruction memory: one synchronous write port, one synchronous read port (read-before-write).
module inst_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  word_t                    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output word_t                    rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge write to raddr is not visible here, so the old word is returned
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, stall, redirect and optional halt around inst_mem.
// Optional feature: define IFETCH_HALT_EN to stop fetching on the HALT word.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    output logic [31:0]                   inst,
    output logic [31:0]                   inst_pc,
    output logic                          inst_valid,
    output logic                          halted
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         valid_q, valid_d;
    logic         fetch_c;
    logic         hit_c;
    word_t        rdata;

    // The read register holds mem[pc] as of the fetch edge; valid_q says it is live
    inst_mem #(
        .DEPTH (IMEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch_c),
        .raddr (pc_q[AW-1:0]),
        .rdata (rdata)
    );

`ifdef IFETCH_HALT_EN
    assign hit_c  = valid_q && (rdata == HALT);
    assign halted = (state_q == ST_HALT) || hit_c;
`else
    assign hit_c  = 1'b0;
    assign halted = 1'b0;
`endif

    assign inst_valid = valid_q && !hit_c;
    assign inst       = inst_valid ? rdata : NOP;
    assign inst_pc    = ipc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ipc_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    // Halt beats redirect, redirect beats stall
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fetch_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hit_c) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    fetch_c = 1'b1;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd1;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch against a per-edge behavioural fetch model.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam logic [31:0] NOPW  = 32'h0000_0007;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_valid;
    logic          halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] pc_m, inst_m, ipc_m;
    logic        valid_m, halted_m;
    logic [31:0] abcd [4] = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};

    inst_fetch #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic model_reset();
        pc_m     = 32'h0;
        inst_m   = NOPW;
        ipc_m    = 32'h0;
        valid_m  = 1'b0;
        halted_m = 1'b0;
    endtask

    // One rising edge as the spec describes it; the fetch sees memory before this edge's write
    task automatic model_edge();
        logic [31:0] fw;
        fw = mem_m[pc_m[AW-1:0]];
        if (!halted_m) begin
            if (redirect) begin
                pc_m    = redirect_pc;
                inst_m  = NOPW;
                valid_m = 1'b0;
            end else if (!stall) begin
                if (HALT_EN && fw == HALTW) begin
                    inst_m   = NOPW;
                    valid_m  = 1'b0;
                    halted_m = 1'b1;
                end else begin
                    inst_m  = fw;
                    ipc_m   = pc_m;
                    valid_m = 1'b1;
                end
                pc_m = pc_m + 32'd1;
            end
        end
        if (prog_we) mem_m[prog_addr] = prog_data;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else if (prog_we) mem_m[prog_addr] = prog_data;
        #1;
    endtask

    function automatic logic [65:0] exp_vec();
        return {inst_m, valid_m, halted_m, valid_m ? ipc_m : 32'h0};
    endfunction

    function automatic logic [65:0] got_vec();
        return {inst, inst_valid, halted, valid_m ? inst_pc : 32'h0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        prog_we = 1'b0; prog_addr = '0; prog_data = 32'h0;
        model_reset();
        #3;
        n_cmp++; if (inst !== NOPW) begin n_err++; $display("FAIL reset inst: got %h want %h", inst, NOPW); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset halted: got %b want 0", halted); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = (i < 4) ? abcd[i] : ($urandom & 32'h7FFF_FFFF);
            tick();
        end
        prog_we = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL seq model %0d: got %h want %h", i, got_vec(), exp_vec()); end
            n_cmp++;
            if (inst !== abcd[i] || inst_pc !== 32'(i) || inst_valid !== 1'b1) begin
                n_err++; $display("FAIL seq word %0d: got %h@%0d v%b want %h@%0d v1", i, inst, inst_pc, inst_valid, abcd[i], i);
            end
        end
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_pc = 32'h0; tick();
        redirect = 1'b0; tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (inst !== abcd[1] || inst_pc !== 32'd1 || inst_valid !== 1'b1 || got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL stall hold %0d: got %h@%0d want %h@1", i, inst, inst_pc, abcd[1]);
            end
        end
        stall = 1'b0; tick();
        n_cmp++;
        if (inst !== abcd[2] || inst_pc !== 32'd2 || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL stall release: got %h@%0d want %h@2", inst, inst_pc, abcd[2]);
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; redirect_pc = 32'h0; tick();
        redirect = 1'b0; tick();
        redirect = 1'b1; redirect_pc = 32'd2; stall = 1'b1; tick();
        n_cmp++;
        if (inst !== NOPW || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL redirect nop: got %h v%b want %h v0", inst, inst_valid, NOPW);
        end
        redirect = 1'b0; stall = 1'b0; tick();
        n_cmp++;
        if (inst !== abcd[2] || inst_pc !== 32'd2 || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL redirect target: got %h@%0d want %h@2", inst, inst_pc, abcd[2]);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'd255; tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (inst_pc !== 32'(255 + i) || got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL wrap %0d: got %h@%0d want %h@%0d", i, inst, inst_pc, inst_m, 255 + i);
            end
        end
        n_cmp++;
        if (inst !== abcd[0]) begin n_err++; $display("FAIL wrap word: got %h want %h", inst, abcd[0]); end
    endtask

    task automatic test_rbw();
        logic [31:0] old_w, new_w;
        old_w = mem_m[5];
        new_w = $urandom & 32'h7FFF_FFFF;
        redirect = 1'b1; redirect_pc = 32'd5; tick();
        redirect = 1'b0; prog_we = 1'b1; prog_addr = AW'(5); prog_data = new_w; tick();
        prog_we = 1'b0;
        n_cmp++;
        if (inst !== old_w || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL rbw old: got %h want %h", inst, old_w);
        end
        redirect = 1'b1; tick();
        redirect = 1'b0; tick();
        n_cmp++;
        if (inst !== new_w || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL rbw new: got %h want %h", inst, new_w);
        end
    endtask

    task automatic test_async_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'd9; stall = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (inst !== NOPW || inst_valid !== 1'b0 || inst_pc !== 32'h0 || halted !== 1'b0) begin
            n_err++; $display("FAIL async reset: got %h@%0d v%b h%b want %h@0 v0 h0", inst, inst_pc, inst_valid, halted, NOPW);
        end
        tick();
        redirect = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (inst !== mem_m[0] || inst_pc !== 32'h0 || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset refetch: got %h@%0d want %h@0", inst, inst_pc, mem_m[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 8) == 0;
            redirect_pc = ($urandom % 2) ? $urandom : 32'($urandom % 300);
            prog_we     = ($urandom % 4) == 0;
            prog_addr   = AW'($urandom);
            prog_data   = $urandom & 32'h7FFF_FFFF;
            tick();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random %0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        stall = 1'b0; redirect = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_halt();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_data = (i == 2) ? HALTW : abcd[i];
            tick();
        end
        prog_we = 1'b0;
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL halt word: got %h want %h", got_vec(), exp_vec()); end
        n_cmp++;
        if (HALT_EN) begin
            if (halted !== 1'b1 || inst !== NOPW || inst_valid !== 1'b0) begin
                n_err++; $display("FAIL halt flag: got %h v%b h%b want %h v0 h1", inst, inst_valid, halted, NOPW);
            end
        end else if (halted !== 1'b0 || inst !== HALTW || inst_valid !== 1'b1 || inst_pc !== 32'd2) begin
            n_err++; $display("FAIL halt plain: got %h@%0d v%b h%b want %h@2 v1 h0", inst, inst_pc, inst_valid, halted, HALTW);
        end
        for (int i = 0; i < 4; i++) begin
            redirect = 1'b1; redirect_pc = 32'd1; stall = i[0];
            tick();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL halt freeze %0d: got %h want %h", i, got_vec(), exp_vec()); end
        end
        redirect = 1'b0; stall = 1'b0; tick();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin n_err++; $display("FAIL halt idle: got %h want %h", got_vec(), exp_vec()); end
        #2 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (halted !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL halt clear: got h%b v%b want h0 v0", halted, inst_valid); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (inst !== abcd[0] || inst_pc !== 32'h0 || got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL halt refetch: got %h@%0d want %h@0", inst, inst_pc, abcd[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_rbw();
        test_async_reset();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
